enemy_control: RTL and testbench
================================

ENEMY_CONTROL -- requirements
Module: enemy_control

Parameters
REQ-001 SHALL have parameter INIT_CYCLES, default 16, number of cycles the init output is held after reset.
REQ-002 SHALL have parameter MOVE_DIV, default 4, number of frames per enemy move step (range 1-255).
REQ-003 SHALL have parameter DRAW_TIMEOUT, default 2048, maximum cycles to wait for draw_done.

Interface
REQ-004 SHALL have port clock, input, 1 bit, the single system clock; all flops rise on it.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1 bit, game running; low holds the sequencer in IDLE.
REQ-007 SHALL have port frame_tick, input, 1 bit, one-cycle pulse once per video frame.
REQ-008 SHALL have port draw_done, input, 1 bit, level from the enemies block; high when all three enemies have been drawn.
REQ-009 SHALL have ports init, idle, gen_move, apply_move and draw, each output, 1 bit, registered one-hot state signals to the enemies block.
REQ-010 SHALL have port frame_count, output, 8 bits, frames serviced, wrapping modulo 256.
REQ-011 SHALL have port overrun, output, 1 bit, sticky; set when a frame_tick is lost.
REQ-012 SHALL have port draw_timeout, output, 1 bit, sticky; set when a DRAW_TIMEOUT expiry occurs.

Function
REQ-013 SHALL implement the states INIT, IDLE, GEN_MOVE, APPLY_MOVE and DRAW; exactly one of the five state outputs SHALL be high in every cycle.
REQ-014 INIT SHALL last exactly INIT_CYCLES cycles, then go to IDLE regardless of enable.
REQ-015 IDLE SHALL leave only when enable=1 and (frame_tick=1 or pending=1).
- When move_cnt == MOVE_DIV-1, the next state SHALL be GEN_MOVE and move_cnt SHALL clear.
- Otherwise the next state SHALL be DRAW and move_cnt SHALL increment.
REQ-016 GEN_MOVE SHALL last exactly 1 cycle and go to APPLY_MOVE.
REQ-017 APPLY_MOVE SHALL last exactly 1 cycle and go to DRAW.
REQ-018 DRAW SHALL be held until draw_done=1 is sampled, then go to IDLE on the next edge.
- The draw_done check SHALL be ignored in the first DRAW cycle, because the enemies block needs one cycle to lower a stale done.
REQ-019 DRAW SHALL count its cycles; at DRAW_TIMEOUT cycles without draw_done it SHALL go to IDLE and set draw_timeout.
REQ-020 Latency: with MOVE_DIV reached, the sequence from frame_tick in IDLE SHALL be gen_move high on the next cycle, apply_move on the one after, and draw on the third.
- Without a move, draw SHALL be high on the cycle after frame_tick.
REQ-021 pending SHALL be a one-deep internal flag set by a frame_tick arriving outside IDLE, or in IDLE while enable=0.
- pending SHALL clear when IDLE consumes it.
REQ-022 A frame_tick arriving while pending=1 and not consumed that cycle SHALL set overrun.
REQ-023 Simultaneous IDLE exit and frame_tick SHALL count as a single frame; the tick is consumed and pending is not set.
REQ-024 frame_count SHALL increment by 1 on every IDLE exit and wrap 255->0.
REQ-025 enable falling outside IDLE SHALL NOT abort the current sequence; it takes effect at the next IDLE.
REQ-026 overrun and draw_timeout SHALL clear only on reset.

Reset
REQ-027 reset low SHALL asynchronously force:
- state INIT, so init=1 and all other state outputs=0;
- all counters to 0: init, move, draw-timeout and frame_count;
- pending, overrun and draw_timeout to 0.
REQ-028 Reset asserted mid-DRAW or mid-GEN_MOVE SHALL take effect immediately, with no completion of the sequence; release SHALL restart the INIT_CYCLES count.

Verification
REQ-029 Reset release, enable=1, no ticks -> init high for exactly 16 cycles, then idle=1 stays high; frame_count=0.
REQ-030 MOVE_DIV=4, 8 ticks each answered by draw_done 5 cycles into DRAW -> gen_move pulses only on ticks 4 and 8, each followed by 1 apply_move cycle; frame_count=8.
REQ-031 Tick, then draw_done held low -> DRAW lasts 2048 cycles, then idle=1 and draw_timeout=1 stays set.
REQ-032 A second tick during DRAW -> IDLE exits one cycle after DRAW ends; a third tick during that same DRAW -> overrun=1.
REQ-033 Reset pulsed low during APPLY_MOVE -> all outputs reach reset values within the same cycle; init lasts 16 cycles after release.
REQ-034 enable=0 with a tick in IDLE -> stays IDLE with pending set; enable=1 -> sequence starts next cycle, frame_count increments by 1.

Source files
------------

// File: rtl/enemy_control.sv
// Sequencer for the enemies block: INIT, then one IDLE -> [GEN_MOVE -> APPLY_MOVE ->] DRAW
// pass per video frame, with a one-deep pending tick, frame counter and sticky error flags.
module enemy_control #(
    parameter int unsigned INIT_CYCLES  = 16,
    parameter int unsigned MOVE_DIV     = 4,
    parameter int unsigned DRAW_TIMEOUT = 2048
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic       draw_done,
    output logic       init,
    output logic       idle,
    output logic       gen_move,
    output logic       apply_move,
    output logic       draw,
    output logic [7:0] frame_count,
    output logic       overrun,
    output logic       draw_timeout
);

    localparam int unsigned IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int unsigned DW = (DRAW_TIMEOUT > 1) ? $clog2(DRAW_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_GEN_MOVE,
        S_APPLY_MOVE,
        S_DRAW
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_init_cnt;
    logic [7:0]    r_move_cnt;
    logic [DW-1:0] r_draw_cnt;
    logic [7:0]    r_frame_count;
    logic          r_pending;
    logic          r_overrun;
    logic          r_draw_timeout;
    logic          r_init;
    logic          r_idle;
    logic          r_gen_move;
    logic          r_apply_move;
    logic          r_draw;
    logic          w_go;
    logic          w_move_due;
    logic          w_timeout_hit;

    assign w_move_due = (r_move_cnt == 8'(MOVE_DIV - 1));

    always_comb begin
        w_next        = r_state;
        w_go          = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_INIT: begin
                if (r_init_cnt == IW'(INIT_CYCLES - 1))
                    w_next = S_IDLE;
            end
            S_IDLE: begin
                if (enable && (frame_tick || r_pending)) begin
                    w_go   = 1'b1;
                    w_next = w_move_due ? S_GEN_MOVE : S_DRAW;
                end
            end
            S_GEN_MOVE:   w_next = S_APPLY_MOVE;
            S_APPLY_MOVE: w_next = S_DRAW;
            S_DRAW: begin
                // A done level in the first DRAW cycle may be stale from the previous frame.
                if ((r_draw_cnt != '0) && draw_done) begin
                    w_next = S_IDLE;
                end else if (r_draw_cnt == DW'(DRAW_TIMEOUT - 1)) begin
                    w_next        = S_IDLE;
                    w_timeout_hit = 1'b1;
                end
            end
            default: w_next = S_INIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= S_INIT;
            r_init_cnt     <= '0;
            r_move_cnt     <= '0;
            r_draw_cnt     <= '0;
            r_frame_count  <= '0;
            r_pending      <= 1'b0;
            r_overrun      <= 1'b0;
            r_draw_timeout <= 1'b0;
            r_init         <= 1'b1;
            r_idle         <= 1'b0;
            r_gen_move     <= 1'b0;
            r_apply_move   <= 1'b0;
            r_draw         <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_init       <= (w_next == S_INIT);
            r_idle       <= (w_next == S_IDLE);
            r_gen_move   <= (w_next == S_GEN_MOVE);
            r_apply_move <= (w_next == S_APPLY_MOVE);
            r_draw       <= (w_next == S_DRAW);

            if (r_state == S_INIT)
                r_init_cnt <= r_init_cnt + IW'(1);

            if ((r_state == S_DRAW) && (w_next == S_DRAW))
                r_draw_cnt <= r_draw_cnt + DW'(1);
            else
                r_draw_cnt <= '0;

            if (w_go) begin
                r_move_cnt    <= w_move_due ? 8'd0 : r_move_cnt + 8'd1;
                r_frame_count <= r_frame_count + 8'd1;
            end

            // A tick on the exit cycle is the frame being serviced, not a new one.
            if (w_go) begin
                r_pending <= 1'b0;
            end else if (frame_tick) begin
                r_pending <= 1'b1;
                if (r_pending)
                    r_overrun <= 1'b1;
            end

            if (w_timeout_hit)
                r_draw_timeout <= 1'b1;
        end
    end

    assign init         = r_init;
    assign idle         = r_idle;
    assign gen_move     = r_gen_move;
    assign apply_move   = r_apply_move;
    assign draw         = r_draw;
    assign frame_count  = r_frame_count;
    assign overrun      = r_overrun;
    assign draw_timeout = r_draw_timeout;

endmodule

// File: tb/tb_enemy_control.sv
// Randomised frame stimulus for enemy_control; a scoreboard of expected frame services
// is checked by a monitor each time the sequencer leaves IDLE.
module tb_enemy_control;

    localparam int INIT_C = 16;
    localparam int MDIV   = 4;
    localparam int DTO    = 2048;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       frame_tick;
    logic       draw_done;
    logic       init;
    logic       idle;
    logic       gen_move;
    logic       apply_move;
    logic       draw;
    logic [7:0] frame_count;
    logic       overrun;
    logic       draw_timeout;

    enemy_control #(
        .INIT_CYCLES (INIT_C),
        .MOVE_DIV    (MDIV),
        .DRAW_TIMEOUT(DTO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .frame_tick  (frame_tick),
        .draw_done   (draw_done),
        .init        (init),
        .idle        (idle),
        .gen_move    (gen_move),
        .apply_move  (apply_move),
        .draw        (draw),
        .frame_count (frame_count),
        .overrun     (overrun),
        .draw_timeout(draw_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit         move;
        logic [7:0] fc;
        int         dlen;
    } exp_t;

    exp_t exp_q[$];
    int   delay_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   n_frames   = 0;
    bit   exp_overrun = 0;

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // Reference: the k-th serviced frame since reset moves on every MOVE_DIV-th frame,
    // reports k mod 256, and draws for max(done delay, 2) cycles or the full timeout.
    task automatic push_frame(input int delay);
        exp_t e;
        n_frames++;
        e.move = ((n_frames % MDIV) == 0);
        e.fc   = 8'(n_frames % 256);
        e.dlen = (delay == 0) ? DTO : ((delay < 2) ? 2 : delay);
        exp_q.push_back(e);
        delay_q.push_back(delay);
    endtask

    // Enemies-block stand-in: raises done a chosen number of cycles into DRAW (0 = never).
    int rsp_cyc = 0;
    int rsp_dly = 0;
    bit rsp_in  = 0;
    always @(negedge clock) begin
        if (reset && draw) begin
            if (!rsp_in) begin
                rsp_in  = 1;
                rsp_cyc = 0;
                rsp_dly = (delay_q.size() != 0) ? delay_q.pop_front() : 0;
            end
            rsp_cyc++;
            draw_done = (rsp_dly != 0) && (rsp_cyc >= rsp_dly);
        end else begin
            rsp_in    = 0;
            draw_done = 1'b0;
        end
    end

    exp_t cur;
    bit   in_seq = 0, prev_idle = 0, prev_gen = 0, prev_apply = 0;
    int   dlen = 0;
    always @(negedge clock) begin
        if (!reset) begin
            in_seq    = 0;
            prev_idle = 0;
            prev_gen  = 0;
            prev_apply = 0;
        end else begin
            check("one_hot", $countones({init, idle, gen_move, apply_move, draw}), 1);
            if (prev_idle && !idle) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("gen_move_at_start", int'(gen_move), int'(cur.move));
                    check("draw_at_start", int'(draw), int'(!cur.move));
                    check("frame_count", int'(frame_count), int'(cur.fc));
                    in_seq = 1;
                    dlen   = 0;
                end
            end
            if (in_seq) begin
                if (prev_gen)   check("apply_after_gen", int'(apply_move), 1);
                if (prev_apply) check("draw_after_apply", int'(draw), 1);
                if (draw) dlen++;
                if (idle) begin
                    in_seq = 0;
                    check("draw_length", dlen, cur.dlen);
                end
            end
            prev_idle  = idle;
            prev_gen   = gen_move;
            prev_apply = apply_move;
        end
    end

    task automatic wait_idle2();
        int stable = 0;
        int t = 0;
        while (stable < 2 && t < 5000) begin
            @(negedge clock);
            t++;
            stable = idle ? stable + 1 : 0;
        end
        if (stable < 2) check("idle_wait_timeout", 0, 1);
    endtask

    task automatic wait_draw();
        int t = 0;
        while (!draw && t < 10) begin
            @(negedge clock);
            t++;
        end
        if (!draw) check("draw_wait_timeout", 0, 1);
    endtask

    task automatic tick_frame(input int delay);
        wait_idle2();
        frame_tick = 1'b1;
        push_frame(delay);
        @(negedge clock);
        frame_tick = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_init", int'(init), 1);
        check("rst_idle", int'(idle), 0);
        check("rst_gen_move", int'(gen_move), 0);
        check("rst_apply_move", int'(apply_move), 0);
        check("rst_draw", int'(draw), 0);
        check("rst_frame_count", int'(frame_count), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_draw_timeout", int'(draw_timeout), 0);
    endtask

    task automatic release_and_time_init();
        int cnt = 0;
        @(negedge clock);
        reset = 1'b1;
        while (init && cnt < 100) begin
            cnt++;
            @(negedge clock);
        end
        check("init_cycles", cnt, INIT_C);
        check("idle_after_init", int'(idle), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode, d;
        reset      = 1'b1;
        enable     = 1'b1;
        frame_tick = 1'b0;
        #3 reset = 1'b0;
        #1 check_reset_values();
        repeat (3) @(negedge clock);
        release_and_time_init();
        repeat (5) @(negedge clock);
        check("idle_no_ticks", int'(idle), 1);
        check("fc_no_ticks", int'(frame_count), 0);

        for (int it = 0; it < 300; it++) begin
            mode = int'($urandom_range(0, 9));
            if (mode <= 5) begin
                tick_frame(int'($urandom_range(1, 8)));
            end else if (mode <= 7) begin
                tick_frame(int'($urandom_range(3, 8)));
                wait_draw();
                frame_tick = 1'b1;
                enable     = 1'b0;
                push_frame(int'($urandom_range(1, 8)));
                @(negedge clock);
                enable = 1'b1;
                if (mode == 7) exp_overrun = 1;
                frame_tick = (mode == 7);
                @(negedge clock);
                frame_tick = 1'b0;
            end else begin
                wait_idle2();
                enable     = 1'b0;
                frame_tick = 1'b1;
                @(negedge clock);
                frame_tick = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clock);
                check("idle_while_disabled", int'(idle), 1);
                enable = 1'b1;
                push_frame(int'($urandom_range(1, 8)));
            end
            wait_idle2();
            check("overrun_flag", int'(overrun), int'(exp_overrun));
        end
        check("fc_after_random", int'(frame_count), n_frames % 256);
        check("scoreboard_drained", exp_q.size(), 0);
        check("no_timeout_yet", int'(draw_timeout), 0);

        tick_frame(0);
        wait_idle2();
        check("draw_timeout_set", int'(draw_timeout), 1);
        tick_frame(2);
        wait_idle2();
        check("draw_timeout_sticky", int'(draw_timeout), 1);

        while (((n_frames + 1) % MDIV) != 0) tick_frame(1);
        tick_frame(1);
        begin
            int t = 0;
            while (!apply_move && t < 10) begin
                @(negedge clock);
                t++;
            end
            check("reached_apply", int'(apply_move), 1);
        end
        #2 reset = 1'b0;
        #1 check_reset_values();
        exp_q.delete();
        delay_q.delete();
        n_frames    = 0;
        exp_overrun = 0;
        repeat (2) @(negedge clock);
        release_and_time_init();
        tick_frame(3);
        wait_idle2();
        check("fc_after_reset", int'(frame_count), 1);
        check("scoreboard_final", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
